// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetches and data loads/stores onto one single-port,
// word-wide RAM. Data requests win ties; misaligned data accesses complete at once without touching the RAM.
module mem_arbiter #(
    parameter int WORD_W       = 32,
    parameter int LDST_WIDTH_W = 2
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    imem_ren,
    input  logic [WORD_W-1:0]       imem_addr,
    input  logic                    dmem_ren,
    input  logic                    dmem_wen,
    input  logic [WORD_W-1:0]       dmem_addr,
    input  logic [WORD_W-1:0]       dmem_store,
    input  logic [LDST_WIDTH_W-1:0] dmem_width,
    output logic                    ihit,
    output logic [WORD_W-1:0]       imem_load,
    output logic                    dhit,
    output logic [WORD_W-1:0]       dmem_load,
    output logic                    misalign,
    output logic                    ram_ren,
    output logic                    ram_wen,
    output logic [WORD_W-1:0]       ram_addr,
    output logic [WORD_W-1:0]       ram_wdata,
    output logic [3:0]              ram_be,
    input  logic [WORD_W-1:0]       ram_rdata,
    input  logic                    ram_ready,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    localparam logic [LDST_WIDTH_W-1:0] WIDTH_BYTE = LDST_WIDTH_W'(0);
    localparam logic [LDST_WIDTH_W-1:0] WIDTH_HALF = LDST_WIDTH_W'(1);

    state_t                  state;
    state_t                  next_state;
    logic [WORD_W-1:0]       lat_addr;
    logic [LDST_WIDTH_W-1:0] lat_width;
    logic [WORD_W-1:0]       lat_store;
    logic                    lat_write;

    logic d_req;
    logic d_misaligned;
    logic take_data;
    logic take_inst;

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    assign d_req = dmem_ren | dmem_wen;

    // Reserved width encoding falls through to the word rule.
    always_comb begin
        d_misaligned = 1'b0;
        if (dmem_width == WIDTH_BYTE) begin
            d_misaligned = 1'b0;
        end else if (dmem_width == WIDTH_HALF) begin
            d_misaligned = dmem_addr[0];
        end else begin
            d_misaligned = (dmem_addr[1:0] != 2'b00);
        end
    end

    assign take_data = (state == IDLE) && d_req && !d_misaligned;
    assign take_inst = (state == IDLE) && !d_req && imem_ren;

    // State register and request latches.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            lat_addr  <= '0;
            lat_width <= '0;
            lat_store <= '0;
            lat_write <= 1'b0;
        end else begin
            state <= next_state;
            if (take_data) begin
                lat_addr  <= dmem_addr;
                lat_width <= dmem_width;
                lat_store <= dmem_store;
                lat_write <= dmem_wen;
            end else if (take_inst) begin
                lat_addr  <= imem_addr;
                lat_width <= '0;
                lat_store <= '0;
                lat_write <= 1'b0;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (take_data) begin
                    next_state = DBUSY;
                end else if (take_inst) begin
                    next_state = IBUSY;
                end else begin
                    next_state = IDLE;
                end
            end
            IBUSY, DBUSY: begin
                if (ram_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign load_byte = ram_rdata[{lat_addr[1:0], 3'b000} +: 8];
    assign load_half = ram_rdata[{lat_addr[1], 4'b0000} +: 16];

    // Output logic; everything is forced low while reset is asserted.
    always_comb begin
        ihit      = 1'b0;
        imem_load = '0;
        dhit      = 1'b0;
        dmem_load = '0;
        misalign  = 1'b0;
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_be    = 4'h0;
        dbg_state = state;
        if (nRST) begin
            case (state)
                IDLE: begin
                    if (d_req && d_misaligned) begin
                        dhit     = 1'b1;
                        misalign = 1'b1;
                    end
                end
                IBUSY: begin
                    ram_ren  = 1'b1;
                    ram_addr = {lat_addr[WORD_W-1:2], 2'b00};
                    ram_be   = 4'hF;
                    if (ram_ready) begin
                        ihit      = 1'b1;
                        imem_load = ram_rdata;
                    end
                end
                DBUSY: begin
                    ram_addr = {lat_addr[WORD_W-1:2], 2'b00};
                    if (lat_write) begin
                        ram_wen = 1'b1;
                        if (lat_width == WIDTH_BYTE) begin
                            ram_wdata = {4{lat_store[7:0]}};
                            ram_be    = 4'b0001 << lat_addr[1:0];
                        end else if (lat_width == WIDTH_HALF) begin
                            ram_wdata = {2{lat_store[15:0]}};
                            ram_be    = 4'b0011 << lat_addr[1:0];
                        end else begin
                            ram_wdata = lat_store;
                            ram_be    = 4'hF;
                        end
                    end else begin
                        ram_ren = 1'b1;
                        ram_be  = 4'hF;
                    end
                    if (ram_ready) begin
                        dhit = 1'b1;
                        if (!lat_write) begin
                            if (lat_width == WIDTH_BYTE) begin
                                dmem_load = WORD_W'(load_byte);
                            end else if (lat_width == WIDTH_HALF) begin
                                dmem_load = WORD_W'(load_half);
                            end else begin
                                dmem_load = ram_rdata;
                            end
                        end
                    end
                end
                default: begin
                    dbg_state = state;
                end
            endcase
        end
    end

endmodule
